// File: rtl/ad9866_rx_deinterleave.sv
// AD9866 6-bit nibble-mode receive front end: pair alignment, sample rebuild,
// clip flagging and a small valid/ready FIFO toward the DDC inputs.
module ad9866_rx_deinterleave #(
    parameter int LOCK_PAIRS = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         rx_nib,
    input  logic               rx_sync,
    input  logic               clear,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [11:0]        out_sample,
    output logic               out_clip,
    output logic               locked,
    output logic               lock_lost,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [3:0] LOCK_N = 4'(LOCK_PAIRS);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0] FULL_XOR = {1'b1, {FIFO_AW{1'b0}}};

    logic [5:0]  nib_q;
    logic        sync_q;
    logic [5:0]  hi;
    logic        have_hi;
    state_t      state;
    logic [3:0]  good_cnt;

    logic [12:0]      mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;

    logic        pair_done;
    logic        pair_err;
    logic [11:0] word;
    logic        clip;
    logic [3:0]  good_next;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        wr_en;
    logic        drop;

    assign pair_done = !sync_q && have_hi;
    assign pair_err  = (sync_q == have_hi);
    assign word      = {hi, nib_q};
    assign clip      = (word == 12'h7FF) || (word == 12'h800);
    assign good_next = good_cnt + 4'd1;
    // The pair that reaches the lock count is the first one delivered.
    assign push      = pair_done && (state == LOCKED || good_next == LOCK_N);

    assign empty = (wptr == rptr);
    assign full  = ((wptr ^ rptr) == FULL_XOR);
    assign pop   = !empty && out_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign out_valid = !empty;
    assign {out_clip, out_sample} = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_q   <= '0;
            sync_q  <= 1'b0;
            hi      <= '0;
            have_hi <= 1'b0;
        end else begin
            nib_q  <= rx_nib;
            sync_q <= rx_sync;
            if (sync_q) begin
                hi      <= nib_q;
                have_hi <= 1'b1;
            end else begin
                have_hi <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            good_cnt  <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (pair_done) begin
                        good_cnt <= good_next;
                        if (good_next == LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (pair_err) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (pair_err) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
            endcase
            if (clear)
                lock_lost <= 1'b0;
            else if (state == LOCKED && pair_err)
                lock_lost <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr[FIFO_AW-1:0]] <= {clip, word};
                wptr <= wptr + PTR_ONE;
            end
            if (pop)
                rptr <= rptr + PTR_ONE;
            unique case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + PTR_ONE;
                2'b01:   fifo_level <= fifo_level - PTR_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (clear)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ad9866_rx_deinterleave.sv
// Randomised and directed bench for ad9866_rx_deinterleave with a
// queue-based reference model of the nibble stream.
module tb_ad9866_rx_deinterleave;

    localparam int LP    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [5:0]    rx_nib;
    logic          rx_sync;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [11:0]   out_sample;
    logic          out_clip;
    logic          locked;
    logic          lock_lost;
    logic          overflow;
    logic [AW:0]   fifo_level;

    ad9866_rx_deinterleave #(.LOCK_PAIRS(LP), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_nib(rx_nib), .rx_sync(rx_sync),
        .clear(clear), .out_ready(out_ready), .out_valid(out_valid),
        .out_sample(out_sample), .out_clip(out_clip), .locked(locked),
        .lock_lost(lock_lost), .overflow(overflow), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic rdy;
    logic [12:0] seen[$];
    logic [12:0] mq[$];

    logic [5:0] m_nib, m_hi;
    logic m_sync, m_have, m_lock, m_lost, m_ovf;
    int m_good;

    function automatic logic [12:0] entry(input logic [11:0] s);
        return {(s == 12'h7FF) || (s == 12'h800), s};
    endfunction

    // Reference: acts on the nibble captured one edge earlier.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_nib = 0; m_sync = 0; m_hi = 0; m_have = 0;
            m_good = 0; m_lock = 0; m_lost = 0; m_ovf = 0;
        end else begin
            bit pop_m, push_m, err, lost_ev, ovf_ev;
            logic [11:0] smp;
            smp = {m_hi, m_nib};
            pop_m = out_ready && mq.size() > 0;
            push_m = 0; err = 0; lost_ev = 0; ovf_ev = 0;
            if (!m_sync) begin
                if (m_have) begin
                    if (m_lock) push_m = 1;
                    else begin
                        m_good++;
                        if (m_good == LP) begin m_lock = 1; push_m = 1; end
                    end
                end else err = 1;
                m_have = 0;
            end else begin
                if (m_have) err = 1;
                m_hi = m_nib;
                m_have = 1;
            end
            if (err) begin
                m_good = 0;
                if (m_lock) begin m_lock = 0; lost_ev = 1; end
            end
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                if (mq.size() < DEPTH) mq.push_back(entry(smp));
                else ovf_ev = 1;
            end
            if (clear) begin m_lost = 0; m_ovf = 0; end
            else begin
                if (lost_ev) m_lost = 1;
                if (ovf_ev) m_ovf = 1;
            end
            m_nib = rx_nib;
            m_sync = rx_sync;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("level", 32'(fifo_level), mq.size());
        chk("locked", 32'(locked), 32'(m_lock));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0)
            chk("head", 32'({out_clip, out_sample}), 32'(mq[0]));
    endtask

    task automatic tick(input logic [5:0] n, input logic s, input logic c);
        @(negedge clk);
        cmp_all();
        rx_nib = n; rx_sync = s; clear = c; out_ready = rdy;
        if (out_valid && out_ready)
            seen.push_back({out_clip, out_sample});
    endtask

    task automatic pair(input logic [5:0] h, input logic [5:0] l);
        tick(h, 1'b1, 1'b0);
        tick(l, 1'b0, 1'b0);
    endtask

    task automatic chk_seen(input string tag, input int i, input logic [12:0] e);
        chk(tag, (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD_BEEF, 32'(e));
    endtask

    logic [11:0] v[5];
    logic [12:0] exp_clip[5];
    int n0;
    bit hiph;

    initial begin
        rst = 1; rx_nib = 0; rx_sync = 0; clear = 0; out_ready = 1; rdy = 1;
        repeat (3) tick(6'h00, 1'b0, 1'b0);
        rst = 0;
        tick(6'h00, 1'b0, 1'b0);

        // lock, latency and clip
        seen.delete();
        repeat (4) pair(6'h2A, 6'h15);
        tick(6'h2A, 1'b1, 1'b0);
        chk("lock_early", 32'(locked), 0);
        tick(6'h15, 1'b0, 1'b0);
        chk("lock_rise", 32'(locked), 1);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_sample", 32'(out_sample), 32'h0A95);
        pair(6'h1F, 6'h3F);
        pair(6'h20, 6'h00);
        pair(6'h00, 6'h01);
        pair(6'h2A, 6'h15);
        tick(6'h2A, 1'b1, 1'b0);
        exp_clip = '{13'h0A95, 13'h0A95, 13'h17FF, 13'h1800, 13'h0001};
        for (int i = 0; i < 5; i++) chk_seen("clip_seq", i, exp_clip[i]);

        // orphan low nibble, relock, clear
        tick(6'h15, 1'b0, 1'b0);
        tick(6'h15, 1'b0, 1'b0);
        pair(6'h2A, 6'h15);
        chk("unlock", 32'(locked), 0);
        chk("lost_set", 32'(lock_lost), 1);
        n0 = seen.size();
        repeat (2) pair(6'h2A, 6'h15);
        tick(6'h2A, 1'b1, 1'b0);
        chk("hunt_nopush", seen.size(), n0);
        chk("hunt_locked", 32'(locked), 0);
        tick(6'h15, 1'b0, 1'b1);
        tick(6'h2A, 1'b1, 1'b0);
        chk("lost_clr", 32'(lock_lost), 0);
        tick(6'h15, 1'b0, 1'b0);
        chk("relock", 32'(locked), 1);

        // overflow and full push with pop
        rdy = 0; rst = 1;
        tick(6'h00, 1'b0, 1'b0);
        tick(6'h00, 1'b0, 1'b0);
        rst = 0;
        repeat (4) pair(6'h2A, 6'h15);
        for (int i = 1; i < 5; i++) begin
            v[i] = 12'($urandom);
            pair(v[i][11:6], v[i][5:0]);
        end
        tick(6'h11, 1'b1, 1'b0);
        tick(6'h22, 1'b0, 1'b0);
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_head", 32'(out_sample), 32'h0A95);
        rdy = 1;
        tick(6'h33, 1'b1, 1'b1);
        seen.delete();
        tick(6'h0C, 1'b0, 1'b0);
        chk("fpop_level", 32'(fifo_level), 4);
        chk("fpop_ovf", 32'(overflow), 0);
        repeat (8) tick(6'h00, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) chk_seen("drain", i - 1, entry(v[i]));
        chk_seen("drain", 3, 13'h0462);
        chk_seen("drain", 4, 13'h0CCC);
        chk("drain_n", seen.size(), 5);

        // asynchronous reset in mid-cycle
        #2 rst = 1;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sample", 32'(out_sample), 0);
        chk("rst_clip", 32'(out_clip), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_lost", 32'(lock_lost), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_level", 32'(fifo_level), 0);
        tick(6'h00, 1'b0, 1'b0);
        rst = 0;

        // random stream with occasional framing errors
        hiph = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) hiph = ~hiph;
            rdy = ($urandom_range(0, 3) != 0);
            tick(6'($urandom), hiph, $urandom_range(0, 49) == 0);
            hiph = ~hiph;
            if (i == 1500) begin #3; rst = 1; end
            if (i == 1502) rst = 0;
        end
        tick(6'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
